// File: rtl/dds_state_if.sv
// Control/status bundle between the DDS sequencer, its controller and the downstream coder.
interface dds_state_if;
   logic       dds_start;
   logic       dds_abort;
   logic [3:0] i_code;
   logic [7:0] count;
   logic       state_start;
   logic       busy;
   logic       done;
   logic       over_err;

   modport slave (
      input  dds_start, dds_abort, i_code,
      output count, state_start, busy, done, over_err
   );

   modport master (
      output dds_start, dds_abort, i_code,
      input  count, state_start, busy, done, over_err
   );
endinterface

// File: rtl/dds_state.sv
// DDS sequence state machine: ARM marker, prescaled step count up to OVER,
// wait for the coder's over marker (with timeout), then a one-cycle done.
module dds_state #(
   parameter logic [7:0] DIV      = 8'd4,
   parameter logic [7:0] OVER     = 8'd96,
   parameter logic [3:0] OVER_TMO = 4'd4
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   dds_state_if.slave bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   logic [7:0] r_count;
   logic [7:0] w_count_nxt;
   logic [7:0] w_count_inc;
   logic [7:0] r_presc;
   logic [7:0] w_presc_nxt;
   logic [3:0] r_tmo;
   logic [3:0] w_tmo_nxt;
   logic       r_over_err;
   logic       w_over_err_nxt;
   logic       r_state_start;
   logic       r_busy;
   logic       r_done;
   logic [1:0] r_rst_sync;
   logic       w_run_en;
   logic       w_tick;
   logic       w_unused_code;

   // Reset asserts immediately; state changes are held off until release has passed two flops.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_run_en      = r_rst_sync[1];
   assign w_tick        = (r_presc == (DIV - 8'd1));
   assign w_count_inc   = r_count + 8'd1;
   assign w_unused_code = ^bus.i_code[2:0];

   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_presc_nxt    = r_presc;
      w_tmo_nxt      = r_tmo;
      w_over_err_nxt = r_over_err;
      case (r_state)
         S_IDLE: begin
            w_count_nxt = 8'd0;
            if (bus.dds_start && !bus.dds_abort) begin
               w_state_nxt    = S_ARM;
               w_over_err_nxt = 1'b0;
            end
         end
         S_ARM: begin
            w_count_nxt = 8'd0;
            w_presc_nxt = 8'd0;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_tick) begin
               w_presc_nxt = 8'd0;
               w_count_nxt = w_count_inc;
               if (w_count_inc == OVER) begin
                  w_state_nxt = S_WAIT;
                  w_tmo_nxt   = 4'd0;
               end
            end else begin
               w_presc_nxt = r_presc + 8'd1;
            end
         end
         S_WAIT: begin
            // A marker arriving on the last allowed cycle still counts as on time.
            if (bus.i_code[3]) begin
               w_state_nxt = S_DONE;
               w_count_nxt = 8'd0;
            end else if (r_tmo == (OVER_TMO - 4'd1)) begin
               w_state_nxt    = S_DONE;
               w_count_nxt    = 8'd0;
               w_over_err_nxt = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + 4'd1;
            end
         end
         S_DONE: begin
            w_count_nxt = 8'd0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_count_nxt = 8'd0;
            w_state_nxt = S_IDLE;
         end
      endcase
      if (bus.dds_abort && (r_state != S_IDLE)) begin
         w_state_nxt    = S_IDLE;
         w_count_nxt    = 8'd0;
         w_over_err_nxt = r_over_err;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_count       <= 8'd0;
         r_presc       <= 8'd0;
         r_tmo         <= 4'd0;
         r_over_err    <= 1'b0;
         r_state_start <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else if (w_run_en) begin
         r_state       <= w_state_nxt;
         r_count       <= w_count_nxt;
         r_presc       <= w_presc_nxt;
         r_tmo         <= w_tmo_nxt;
         r_over_err    <= w_over_err_nxt;
         r_state_start <= (w_state_nxt == S_ARM);
         r_busy        <= (w_state_nxt != S_IDLE);
         r_done        <= (w_state_nxt == S_DONE);
      end
   end

   assign bus.count       = r_count;
   assign bus.state_start = r_state_start;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.over_err    = r_over_err;
endmodule
